// File: rtl/eth_pkt_pkg.sv
// eth_pkt_pkg: shared state encoding, default sizes and counter sizing for the packet splitter.
package eth_pkt_pkg;
    localparam int HDR_WORDS_DEF = 31;
    localparam int PAY_BYTES_DEF = 400;
    localparam int OUT_BYTES_DEF = 2;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_DONE} state_t;

    function automatic int cnt_width(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction
endpackage

// File: rtl/eth_pkt_splitter_byte_packer.sv
// byte_packer: packs a byte stream MSB-first into OUT_BYTES-wide words; a completed word may be dropped.
module byte_packer #(
    parameter int OUT_BYTES = 2
) (
    input  logic                   clock,
    input  logic                   aclr_n,
    input  logic                   sclr,
    input  logic                   i_valid,
    input  logic [7:0]             i_byte,
    input  logic                   i_flush,
    input  logic                   i_drop,
    output logic [8*OUT_BYTES-1:0] o_word,
    output logic                   o_word_valid,
    output logic                   o_last
);
    localparam int W  = 8 * OUT_BYTES;
    localparam int IW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_word;
    logic          r_wv;
    logic [W-1:0]  w_next;
    logic          w_push;

    assign o_last       = i_valid && (r_idx == IW'(OUT_BYTES - 1));
    assign w_next       = (r_acc << 8) | W'(i_byte);
    assign w_push       = o_last && !i_drop;
    assign o_word       = r_word;
    assign o_word_valid = r_wv;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_idx  <= '0;
            r_acc  <= '0;
            r_word <= '0;
            r_wv   <= 1'b0;
        end else if (sclr) begin
            r_idx  <= '0;
            r_acc  <= '0;
            r_word <= '0;
            r_wv   <= 1'b0;
        end else begin
            r_wv  <= w_push;
            if (w_push) r_word <= w_next;
            r_idx <= (i_flush || o_last) ? '0 : i_valid ? r_idx + IW'(1) : r_idx;
            r_acc <= (i_flush || o_last) ? '0 : i_valid ? w_next : r_acc;
        end
    end
endmodule

// File: rtl/eth_pkt_splitter.sv
// eth_pkt_splitter: splits one framed packet into a parallel header and packed payload words.
module eth_pkt_splitter
    import eth_pkt_pkg::*;
#(
    parameter int HDR_WORDS = HDR_WORDS_DEF,
    parameter int PAY_BYTES = PAY_BYTES_DEF,
    parameter int OUT_BYTES = OUT_BYTES_DEF
) (
    input  logic                     clock,
    input  logic                     aclr_n,
    input  logic                     sclr,
    input  logic [7:0]               datain,
    input  logic                     ena,
    input  logic                     fifo_full,
    output logic                     wren,
    output logic [8*OUT_BYTES-1:0]   data,
    output logic [32*HDR_WORDS-1:0]  o_header,
    output logic                     header_valid,
    output logic                     pkt_done,
    output logic                     err_short,
    output logic                     overflow
);
    localparam int HDR_B = 4 * HDR_WORDS;
    localparam int CW    = cnt_width(HDR_B + PAY_BYTES);

    state_t                 r_state, w_state_nx;
    logic [CW-1:0]          r_cnt;
    logic [32*HDR_WORDS-1:0] r_header;
    logic                   r_hv, r_pd, r_err, r_ovf;
    logic                   r_ena_q;
    logic                   w_hdr_we, w_pay_we, w_hv, w_pd, w_err, w_last;

    assign o_header     = r_header;
    assign header_valid = r_hv;
    assign pkt_done     = r_pd;
    assign err_short    = r_err;
    assign overflow     = r_ovf;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) r_state <= S_IDLE;
        else         r_state <= sclr ? S_IDLE : w_state_nx;
    end

    // A packet only starts on a rising ena, so a packet cut by reset is ignored until ena drops.
    always_comb begin
        w_state_nx = r_state;
        w_hdr_we   = 1'b0;
        w_pay_we   = 1'b0;
        w_hv       = 1'b0;
        w_pd       = 1'b0;
        w_err      = 1'b0;
        if (!ena) begin
            w_state_nx = S_IDLE;
            w_err      = (r_state == S_HDR) || (r_state == S_PAY);
        end else begin
            case (r_state)
                S_IDLE: if (!r_ena_q) begin
                    w_state_nx = S_HDR;
                    w_hdr_we   = 1'b1;
                end
                S_HDR: begin
                    w_hdr_we = 1'b1;
                    if (r_cnt == CW'(HDR_B - 1)) begin
                        w_state_nx = S_PAY;
                        w_hv       = 1'b1;
                    end
                end
                S_PAY: begin
                    w_pay_we = 1'b1;
                    if (r_cnt == CW'(HDR_B + PAY_BYTES - 1)) begin
                        w_state_nx = S_DONE;
                        w_pd       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_cnt    <= '0;
            r_header <= '0;
            r_hv     <= 1'b0;
            r_pd     <= 1'b0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            r_ena_q  <= 1'b1;
        end else if (sclr) begin
            r_cnt    <= '0;
            r_header <= '0;
            r_hv     <= 1'b0;
            r_pd     <= 1'b0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            r_ena_q  <= 1'b1;
        end else begin
            r_cnt   <= !ena ? '0 : (w_hdr_we || w_pay_we) ? r_cnt + CW'(1) : r_cnt;
            if (w_hdr_we) r_header[8*(HDR_B-1-int'(r_cnt)) +: 8] <= datain;
            r_hv    <= w_hv;
            r_pd    <= w_pd;
            r_err   <= w_err;
            r_ovf   <= r_ovf | (w_last & fifo_full);
            r_ena_q <= ena;
        end
    end

    byte_packer #(.OUT_BYTES(OUT_BYTES)) u_packer (
        .clock        (clock),
        .aclr_n       (aclr_n),
        .sclr         (sclr),
        .i_valid      (w_pay_we),
        .i_byte       (datain),
        .i_flush      (!ena),
        .i_drop       (fifo_full),
        .o_word       (data),
        .o_word_valid (wren),
        .o_last       (w_last)
    );
endmodule

// File: tb/tb_eth_pkt_splitter.sv
// tb_eth_pkt_splitter: randomized bench checking the splitter against a packet-level model.
module tb_eth_pkt_splitter;
    localparam int HB = 124;
    localparam int PB = 400;
    localparam int OB = 2;
    localparam int NW = PB / OB;

    logic clock = 1'b0, aclr_n = 1'b0, sclr = 1'b0, ena = 1'b0, fifo_full = 1'b0;
    logic [7:0] datain = '0;
    logic wren, header_valid, pkt_done, err_short, overflow;
    logic [8*OB-1:0] data;
    logic [8*HB-1:0] o_header;

    logic s_ena = 1'b0;
    logic [7:0] s_din = '0;
    logic s_wren, s_hv, s_pd, s_err, s_ovf;
    logic [31:0] s_data;
    logic [63:0] s_hdr;

    int checks = 0, failures = 0, cyc = 0, t0 = 0;
    int o_nw, o_sig, o_hvn, o_hvt, o_pdn, o_pdt, o_errn, o_errt;
    int e_nw, e_sig, e_hv, e_pd, e_err;
    logic [8*HB-1:0] e_hdr;
    logic [7:0]  pkt [0:1023];
    bit          ff  [0:1023];
    logic [7:0]  m_hdr [0:HB-1];
    logic [15:0] m_data = '0;
    bit          m_ovf = 1'b0;

    eth_pkt_splitter dut (
        .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .datain(datain), .ena(ena),
        .fifo_full(fifo_full), .wren(wren), .data(data), .o_header(o_header),
        .header_valid(header_valid), .pkt_done(pkt_done), .err_short(err_short), .overflow(overflow)
    );

    eth_pkt_splitter #(.HDR_WORDS(2), .PAY_BYTES(8), .OUT_BYTES(4)) dut_s (
        .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .datain(s_din), .ena(s_ena),
        .fifo_full(1'b0), .wren(s_wren), .data(s_data), .o_header(s_hdr),
        .header_valid(s_hv), .pkt_done(s_pd), .err_short(s_err), .overflow(s_ovf)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Events are tagged with the index of the sampling edge that produced them, relative to byte 0.
    always @(negedge clock) begin
        if (wren) begin o_nw++; o_sig = o_sig * 33 + (cyc - t0) * 65536 + int'(data); end
        if (header_valid) begin o_hvn++; o_hvt = cyc - t0; end
        if (pkt_done) begin o_pdn++; o_pdt = cyc - t0; end
        if (err_short) begin o_errn++; o_errt = cyc - t0; end
    end

    function automatic int enc(input int cnt, input int t);
        return cnt == 0 ? -1 : (cnt == 1 ? t : -2);
    endfunction

    function automatic int hdr_diff(input logic [8*HB-1:0] a, input logic [8*HB-1:0] b);
        for (int i = 0; i < HB; i++) if (a[8*(HB-1-i) +: 8] !== b[8*(HB-1-i) +: 8]) return i;
        return -1;
    endfunction

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_obs();
        o_nw = 0; o_sig = 0; o_hvn = 0; o_hvt = 0; o_pdn = 0; o_pdt = 0; o_errn = 0; o_errt = 0;
    endtask

    task automatic run_pkt(input int n, input int idle);
        clear_obs();
        t0 = cyc + 1;
        for (int i = 0; i < n; i++) begin
            ena = 1'b1; datain = pkt[i]; fifo_full = ff[i];
            step();
        end
        ena = 1'b0; datain = '0; fifo_full = 1'b0;
        repeat (idle) step();
    endtask

    // Expected behaviour of one packet of n bytes, from the framing rules alone.
    task automatic model_pkt(input int n);
        int c;
        e_nw  = 0;
        e_sig = 0;
        e_hv  = (n >= HB) ? HB - 1 : -1;
        e_pd  = (n >= HB + PB) ? HB + PB - 1 : -1;
        e_err = (n < HB + PB) ? n : -1;
        for (int i = 0; i < HB && i < n; i++) m_hdr[i] = pkt[i];
        for (int j = 0; j < NW; j++) begin
            c = HB + OB * j + OB - 1;
            if (c < n) begin
                if (ff[c]) m_ovf = 1'b1;
                else begin
                    e_nw++;
                    m_data = {pkt[c-1], pkt[c]};
                    e_sig  = e_sig * 33 + c * 65536 + int'(m_data);
                end
            end
        end
        for (int i = 0; i < HB; i++) e_hdr[8*(HB-1-i) +: 8] = m_hdr[i];
    endtask

    task automatic model_clear();
        for (int i = 0; i < HB; i++) m_hdr[i] = '0;
        m_data = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic test_reset();
        aclr_n = 1'b0;
        repeat (3) step();
        checks++; if ({wren, header_valid, pkt_done, err_short, overflow} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", {wren, header_valid, pkt_done, err_short, overflow}); end
        checks++; if (data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", data); end
        checks++; if (o_header !== '0) begin failures++; $display("FAIL reset_header got=%h exp=0", o_header); end
        aclr_n = 1'b1;
        model_clear();
        repeat (3) step();
    endtask

    task automatic test_lengths();
        int lens[3] = '{HB + PB, HB + PB + 4, HB + 201};
        int k;
        string nm;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 1024; i++) begin pkt[i] = (i < HB) ? 8'(i) : 8'(i - HB); ff[i] = 1'b0; end
            run_pkt(lens[t], 4);
            model_pkt(lens[t]);
            nm = $sformatf("len%0d", lens[t]);
            checks++; if (o_nw !== e_nw) begin failures++; $display("FAIL %s wren_count got=%0d exp=%0d", nm, o_nw, e_nw); end
            checks++; if (o_sig !== e_sig) begin failures++; $display("FAIL %s wren_seq got=%0h exp=%0h", nm, o_sig, e_sig); end
            checks++; if (enc(o_hvn, o_hvt) !== e_hv) begin failures++; $display("FAIL %s header_valid got=%0d exp=%0d", nm, enc(o_hvn, o_hvt), e_hv); end
            checks++; if (enc(o_pdn, o_pdt) !== e_pd) begin failures++; $display("FAIL %s pkt_done got=%0d exp=%0d", nm, enc(o_pdn, o_pdt), e_pd); end
            checks++; if (enc(o_errn, o_errt) !== e_err) begin failures++; $display("FAIL %s err_short got=%0d exp=%0d", nm, enc(o_errn, o_errt), e_err); end
            checks++; if (o_header !== e_hdr) begin failures++; k = hdr_diff(o_header, e_hdr); $display("FAIL %s o_header byte%0d got=%h exp=%h", nm, k, o_header[8*(HB-1-k) +: 8], e_hdr[8*(HB-1-k) +: 8]); end
            checks++; if (data !== m_data) begin failures++; $display("FAIL %s data got=%h exp=%h", nm, data, m_data); end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL %s overflow got=%b exp=%b", nm, overflow, m_ovf); end
            if (t == 0) begin
                checks++; if (o_header[991:960] !== 32'h00010203) begin failures++; $display("FAIL hdr_word0 got=%h exp=00010203", o_header[991:960]); end
                checks++; if (data !== 16'h8E8F) begin failures++; $display("FAIL last_word got=%h exp=8e8f", data); end
            end
        end
    endtask

    task automatic test_overflow();
        int k;
        string nm;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 1024; i++) begin pkt[i] = 8'($urandom); ff[i] = 1'b0; end
            if (t == 0) ff[HB + 3] = 1'b1;
            run_pkt(HB + PB, 3);
            model_pkt(HB + PB);
            nm = $sformatf("ovf%0d", t);
            checks++; if (o_nw !== e_nw) begin failures++; $display("FAIL %s wren_count got=%0d exp=%0d", nm, o_nw, e_nw); end
            checks++; if (o_sig !== e_sig) begin failures++; $display("FAIL %s wren_seq got=%0h exp=%0h", nm, o_sig, e_sig); end
            checks++; if (enc(o_hvn, o_hvt) !== e_hv) begin failures++; $display("FAIL %s header_valid got=%0d exp=%0d", nm, enc(o_hvn, o_hvt), e_hv); end
            checks++; if (enc(o_pdn, o_pdt) !== e_pd) begin failures++; $display("FAIL %s pkt_done got=%0d exp=%0d", nm, enc(o_pdn, o_pdt), e_pd); end
            checks++; if (enc(o_errn, o_errt) !== e_err) begin failures++; $display("FAIL %s err_short got=%0d exp=%0d", nm, enc(o_errn, o_errt), e_err); end
            checks++; if (o_header !== e_hdr) begin failures++; k = hdr_diff(o_header, e_hdr); $display("FAIL %s o_header byte%0d got=%h exp=%h", nm, k, o_header[8*(HB-1-k) +: 8], e_hdr[8*(HB-1-k) +: 8]); end
            checks++; if (data !== m_data) begin failures++; $display("FAIL %s data got=%h exp=%h", nm, data, m_data); end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL %s overflow got=%b exp=%b", nm, overflow, m_ovf); end
        end
    endtask

    task automatic test_sclr();
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        model_clear();
        checks++; if ({wren, header_valid, pkt_done, err_short, overflow} !== 5'b0) begin failures++; $display("FAIL sclr_strobes got=%b exp=00000", {wren, header_valid, pkt_done, err_short, overflow}); end
        checks++; if (data !== '0) begin failures++; $display("FAIL sclr_data got=%h exp=0", data); end
        checks++; if (o_header !== '0) begin failures++; $display("FAIL sclr_header got=%h exp=0", o_header); end
        step();
    endtask

    task automatic test_random();
        int n, k;
        string nm;
        for (int t = 0; t < 8; t++) begin
            n = (t == 0) ? HB + PB : $urandom_range(1, HB + PB + 16);
            for (int i = 0; i < 1024; i++) begin pkt[i] = 8'($urandom); ff[i] = ($urandom_range(0, 15) == 0); end
            run_pkt(n, $urandom_range(1, 3));
            model_pkt(n);
            nm = $sformatf("rnd%0d_n%0d", t, n);
            checks++; if (o_nw !== e_nw) begin failures++; $display("FAIL %s wren_count got=%0d exp=%0d", nm, o_nw, e_nw); end
            checks++; if (o_sig !== e_sig) begin failures++; $display("FAIL %s wren_seq got=%0h exp=%0h", nm, o_sig, e_sig); end
            checks++; if (enc(o_hvn, o_hvt) !== e_hv) begin failures++; $display("FAIL %s header_valid got=%0d exp=%0d", nm, enc(o_hvn, o_hvt), e_hv); end
            checks++; if (enc(o_pdn, o_pdt) !== e_pd) begin failures++; $display("FAIL %s pkt_done got=%0d exp=%0d", nm, enc(o_pdn, o_pdt), e_pd); end
            checks++; if (enc(o_errn, o_errt) !== e_err) begin failures++; $display("FAIL %s err_short got=%0d exp=%0d", nm, enc(o_errn, o_errt), e_err); end
            checks++; if (o_header !== e_hdr) begin failures++; k = hdr_diff(o_header, e_hdr); $display("FAIL %s o_header byte%0d got=%h exp=%h", nm, k, o_header[8*(HB-1-k) +: 8], e_hdr[8*(HB-1-k) +: 8]); end
            checks++; if (data !== m_data) begin failures++; $display("FAIL %s data got=%h exp=%h", nm, data, m_data); end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL %s overflow got=%b exp=%b", nm, overflow, m_ovf); end
        end
    endtask

    task automatic test_async_reset();
        int k;
        for (int i = 0; i < 1024; i++) begin pkt[i] = 8'($urandom); ff[i] = 1'b0; end
        clear_obs();
        t0 = cyc + 1;
        for (int i = 0; i < HB + 50; i++) begin
            ena = 1'b1; datain = pkt[i];
            step();
        end
        datain = pkt[HB + 50];
        #2 aclr_n = 1'b0;
        #1;
        checks++; if ({wren, header_valid, pkt_done, err_short, overflow} !== 5'b0) begin failures++; $display("FAIL areset_strobes got=%b exp=00000", {wren, header_valid, pkt_done, err_short, overflow}); end
        checks++; if (data !== '0 || o_header !== '0) begin failures++; $display("FAIL areset_data_hdr got=%h/%h exp=0/0", data, o_header[991:960]); end
        step();
        aclr_n = 1'b1;
        model_clear();
        clear_obs();
        for (int i = HB + 51; i < HB + PB; i++) begin
            datain = pkt[i];
            step();
        end
        ena = 1'b0;
        repeat (3) step();
        checks++; if (o_nw + o_hvn + o_pdn + o_errn !== 0) begin failures++; $display("FAIL areset_ignore got=%0d/%0d/%0d/%0d exp=0/0/0/0", o_nw, o_hvn, o_pdn, o_errn); end
        checks++; if (o_header !== '0) begin failures++; $display("FAIL areset_hdr_hold got=%h exp=0", o_header[991:960]); end
        run_pkt(HB + PB, 3);
        model_pkt(HB + PB);
        checks++; if (o_nw !== e_nw) begin failures++; $display("FAIL after_rst wren_count got=%0d exp=%0d", o_nw, e_nw); end
        checks++; if (o_sig !== e_sig) begin failures++; $display("FAIL after_rst wren_seq got=%0h exp=%0h", o_sig, e_sig); end
        checks++; if (enc(o_hvn, o_hvt) !== e_hv) begin failures++; $display("FAIL after_rst header_valid got=%0d exp=%0d", enc(o_hvn, o_hvt), e_hv); end
        checks++; if (enc(o_pdn, o_pdt) !== e_pd) begin failures++; $display("FAIL after_rst pkt_done got=%0d exp=%0d", enc(o_pdn, o_pdt), e_pd); end
        checks++; if (enc(o_errn, o_errt) !== e_err) begin failures++; $display("FAIL after_rst err_short got=%0d exp=%0d", enc(o_errn, o_errt), e_err); end
        checks++; if (o_header !== e_hdr) begin failures++; k = hdr_diff(o_header, e_hdr); $display("FAIL after_rst o_header byte%0d got=%h exp=%h", k, o_header[8*(HB-1-k) +: 8], e_hdr[8*(HB-1-k) +: 8]); end
        checks++; if (data !== m_data) begin failures++; $display("FAIL after_rst data got=%h exp=%h", data, m_data); end
        checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL after_rst overflow got=%b exp=%b", overflow, m_ovf); end
    endtask

    task automatic test_small_params();
        int nw = 0, pd_ok = 0, nerr = 0, nhv = 0;
        logic [31:0] d0 = '0, d1 = '0;
        for (int i = 0; i < 20; i++) begin
            if (s_wren) begin
                if (nw == 0) d0 = s_data; else d1 = s_data;
                nw++;
                if (s_pd) pd_ok++;
            end
            if (s_pd && !s_wren) pd_ok += 100;
            nerr += int'(s_err);
            nhv  += int'(s_hv);
            s_ena = (i < 16);
            s_din = 8'(16 + i);
            step();
        end
        checks++; if (s_hdr !== 64'h1011121314151617) begin failures++; $display("FAIL small_header got=%h exp=1011121314151617", s_hdr); end
        checks++; if (nw !== 2) begin failures++; $display("FAIL small_wren_count got=%0d exp=2", nw); end
        checks++; if (d0 !== 32'h18191A1B) begin failures++; $display("FAIL small_word0 got=%h exp=18191a1b", d0); end
        checks++; if (d1 !== 32'h1C1D1E1F) begin failures++; $display("FAIL small_word1 got=%h exp=1c1d1e1f", d1); end
        checks++; if (pd_ok !== 1) begin failures++; $display("FAIL small_pkt_done got=%0d exp=1", pd_ok); end
        checks++; if (nhv !== 1 || nerr !== 0) begin failures++; $display("FAIL small_hv_err got=%0d/%0d exp=1/0", nhv, nerr); end
    endtask

    initial begin
        test_reset();
        test_lengths();
        test_overflow();
        test_sclr();
        test_random();
        test_async_reset();
        test_small_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
